// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types for the common-data-bus arbiter slice.
//   issue_eu_t     : execution-unit identifiers (index into the request vector)
//   EU_N           : number of execution units in the base configuration
//   cdb_data_t     : one CDB payload (ROB tag, result value, exception info)
//   CDB_RR_PTR_LEN : width of the round-robin pointer
// Ports: none (package).
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int XLEN        = 64;
  localparam int ROB_DEPTH   = 8;
  localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);

  typedef enum logic [2:0] {
    EU_LOAD_BUFFER   = 3'd0,
    EU_STORE_BUFFER  = 3'd1,
    EU_BRANCH_UNIT   = 3'd2,
    EU_INT_ALU       = 3'd3,
    EU_OPERANDS_ONLY = 3'd4
  } issue_eu_t;

  localparam int EU_N           = 5;
  localparam int CDB_RR_PTR_LEN = $clog2(EU_N);

  // 3 + 64 + 1 + 5 = 73 bits
  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob_idx;
    logic [XLEN-1:0]        res_value;
    logic                   except_raised;
    logic [4:0]             except_code;
  } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Handshake bundle between the execution units, the arbiter and the CDB
// consumers.
//   valid_i / data_i / ready_o : per-EU result request, payload and grant
//   valid_o / data_o           : registered CDB word
//   rob_ready_i                : consumers accept the CDB word this cycle
// Modports: slave (arbiter side), master (EU / consumer side).
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int N_EU = cdb_arbiter_pkg::EU_N
) ();
  import cdb_arbiter_pkg::*;

  logic [N_EU-1:0] valid_i;
  cdb_data_t       data_i [N_EU];
  logic [N_EU-1:0] ready_o;
  logic            valid_o;
  cdb_data_t       data_o;
  logic            rob_ready_i;

  modport slave (
    input  valid_i, data_i, rob_ready_i,
    output ready_o, valid_o, data_o
  );

  modport master (
    output valid_i, data_i, rob_ready_i,
    input  ready_o, valid_o, data_o
  );

endinterface

// File: rtl/cdb_rr_selector.sv
// -----------------------------------------------------------------------------
// cdb_rr_selector
// Combinational rotated priority encoder: picks the first set request bit
// scanning upward from rr_ptr, wrapping N_EU-1 -> 0 (N_EU need not be a power
// of two, so the wrap uses an explicit modulo).
//   req       : request vector
//   rr_ptr    : first index to consider
//   grant     : one-hot winner (all zero when no request)
//   winner    : encoded winner index
//   any_valid : at least one request present
// -----------------------------------------------------------------------------
module cdb_rr_selector import cdb_arbiter_pkg::*; #(
  parameter int N_EU  = EU_N,
  parameter int PTR_W = CDB_RR_PTR_LEN
) (
  input  logic [N_EU-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_EU-1:0]  grant,
  output logic [PTR_W-1:0] winner,
  output logic             any_valid
);

  logic found_s;
  int   idx_s;

  // Rotated scan: first request at or above rr_ptr, modulo N_EU
  always_comb begin
    grant   = '0;
    winner  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N_EU; k++) begin
      idx_s = (int'(rr_ptr) + k) % N_EU;
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        winner       = PTR_W'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the common data bus with one registered output slot.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : pipeline flush, discards the pending CDB word
//   bus (slave)  : valid_i/data_i/ready_o toward the EUs,
//                  valid_o/data_o/rob_ready_i toward ROB/RS/register status
// Optional feature macro: LEN5_CDB_LB_PRIO_EN -- load buffer wins over the
// round-robin and does not move the pointer.
// -----------------------------------------------------------------------------
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int N_EU   = EU_N,
  parameter int DATA_W = $bits(cdb_data_t)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (N_EU > 1) ? $clog2(N_EU) : 1;

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [PTR_W-1:0]  rr_ptr_r;

  logic [N_EU-1:0]   rr_grant_s;
  logic [PTR_W-1:0]  rr_winner_s;
  logic              rr_any_s;
  logic [N_EU-1:0]   sel_grant_s;
  logic [PTR_W-1:0]  sel_winner_s;
  logic              lb_win_s;
  logic              can_load_s;
  logic              fire_s;
  logic [PTR_W-1:0]  next_ptr_s;

  cdb_rr_selector #(
    .N_EU  (N_EU),
    .PTR_W (PTR_W)
  ) u_sel (
    .req       (bus.valid_i),
    .rr_ptr    (rr_ptr_r),
    .grant     (rr_grant_s),
    .winner    (rr_winner_s),
    .any_valid (rr_any_s)
  );

  // Final winner: round-robin result, optionally overridden by the load buffer
  always_comb begin
    sel_grant_s  = rr_grant_s;
    sel_winner_s = rr_winner_s;
    lb_win_s     = 1'b0;
`ifdef LEN5_CDB_LB_PRIO_EN
    if (bus.valid_i[int'(EU_LOAD_BUFFER)]) begin
      sel_grant_s                      = '0;
      sel_grant_s[int'(EU_LOAD_BUFFER)] = 1'b1;
      sel_winner_s                     = PTR_W'(int'(EU_LOAD_BUFFER));
      lb_win_s                         = 1'b1;
    end else begin
      lb_win_s = 1'b0;
    end
`endif
  end

  // The slot can take a new word when empty or when it drains this cycle
  assign can_load_s = !valid_r || bus.rob_ready_i;
  assign fire_s     = can_load_s && !flush_i && !rst_i && rr_any_s;
  assign next_ptr_s = PTR_W'((int'(sel_winner_s) + 1) % N_EU);

  assign bus.ready_o = fire_s ? sel_grant_s : '0;
  assign bus.valid_o = valid_r;
  assign bus.data_o  = data_r;

  // Output slot and round-robin pointer; flush beats a same-cycle drain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r  <= 1'b0;
      data_r   <= '0;
      rr_ptr_r <= '0;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (fire_s) begin
      valid_r <= 1'b1;
      data_r  <= DATA_W'(bus.data_i[sel_winner_s]);
      if (!lb_win_s) begin
        rr_ptr_r <= next_ptr_s;
      end
    end else if (bus.rob_ready_i) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = EU_N;
`ifdef LEN5_CDB_LB_PRIO_EN
  localparam bit LB_PRIO = 1'b1;
`else
  localparam bit LB_PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_EU(N)) bus ();

  cdb_arbiter #(.N_EU(N)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pointer, output slot
  int        m_ptr   = 0;
  bit        m_valid = 1'b0;
  cdb_data_t m_data  = '0;

  function automatic int ref_winner(logic [N-1:0] v, int ptr);
    if (LB_PRIO && v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = ref_winner(bus.valid_i, m_ptr);
    if (!rst && !flush && w >= 0 && (!m_valid || bus.rob_ready_i)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic set_eu_data(input int i);
    bus.data_i[i].rob_idx       = 3'(i);
    bus.data_i[i].res_value     = {$urandom(), $urandom()};
    bus.data_i[i].except_raised = 1'($urandom_range(0, 1));
    bus.data_i[i].except_code   = 5'($urandom_range(0, 31));
  endtask

  // Advance one clock edge and update the model from the inputs that edge saw
  task automatic edge_update();
    int w;
    logic [N-1:0] r;
    w = ref_winner(bus.valid_i, m_ptr);
    r = ref_ready();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_ptr = 0;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (r != '0) begin
      m_valid = 1'b1;
      m_data  = bus.data_i[w];
      if (!(LB_PRIO && w == 0)) m_ptr = (w + 1) % N;
    end else if (bus.rob_ready_i) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.valid_i = 5'b11111; bus.rob_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00000) begin n_fail++; $display("FAIL reset_ready got=%b exp=%b", bus.ready_o, 5'b00000); end
    edge_update();
    n_tests++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    rst = 1'b0; bus.valid_i = 5'b00000;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00000) begin n_fail++; $display("FAIL idle_ready got=%b exp=%b", bus.ready_o, 5'b00000); end
    edge_update();
    n_tests++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", bus.valid_o); end
    // load a word, then reset while it is pending
    bus.valid_i = 5'b00001; bus.rob_ready_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00001) begin n_fail++; $display("FAIL load_ready got=%b exp=%b", bus.ready_o, 5'b00001); end
    edge_update();
    bus.valid_i = 5'b00000; set_eu_data(0);
    n_tests++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL load_valid got=%b exp=1", bus.valid_o); end
    rst = 1'b1;
    edge_update();
    n_tests++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid got=%b exp=0", bus.valid_o); end
    rst = 1'b0; bus.rob_ready_i = 1'b1;
  endtask

  task automatic test_rotate();
    cdb_data_t d;
    logic [N-1:0] exp;
    bus.valid_i = 5'b11111; bus.rob_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp = '0; exp[i % N] = 1'b1;
      @(negedge clk);
      n_tests++; if (bus.ready_o !== exp) begin n_fail++; $display("FAIL rotate_ready[%0d] got=%b exp=%b", i, bus.ready_o, exp); end
      d = bus.data_i[i % N];
      edge_update();
      set_eu_data(i % N);
      n_tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== d || bus.data_o.rob_idx !== 3'(i % N)) begin
        n_fail++; $display("FAIL rotate_data[%0d] got=%b/%h exp=1/%h", i, bus.valid_o, bus.data_o, d);
      end
    end
  endtask

  task automatic test_wrap_skip();
    bus.valid_i = 5'b01000; bus.rob_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b01000) begin n_fail++; $display("FAIL wrap_pre got=%b exp=%b", bus.ready_o, 5'b01000); end
    edge_update(); set_eu_data(3);
    bus.valid_i = 5'b01001;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00001) begin n_fail++; $display("FAIL wrap_eu0 got=%b exp=%b", bus.ready_o, 5'b00001); end
    edge_update(); set_eu_data(0);
    n_tests++; if (bus.data_o.rob_idx !== 3'd0) begin n_fail++; $display("FAIL wrap_tag0 got=%0d exp=0", bus.data_o.rob_idx); end
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b01000) begin n_fail++; $display("FAIL skip_eu3 got=%b exp=%b", bus.ready_o, 5'b01000); end
    edge_update(); set_eu_data(3);
    n_tests++; if (bus.data_o.rob_idx !== 3'd3) begin n_fail++; $display("FAIL skip_tag3 got=%0d exp=3", bus.data_o.rob_idx); end
  endtask

  task automatic test_lb_prio();
    bus.valid_i = 5'b00010; bus.rob_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00010) begin n_fail++; $display("FAIL lb_pre got=%b exp=%b", bus.ready_o, 5'b00010); end
    edge_update(); set_eu_data(1);
    bus.valid_i = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (bus.ready_o !== 5'b00001) begin n_fail++; $display("FAIL lb_win[%0d] got=%b exp=%b", i, bus.ready_o, 5'b00001); end
      edge_update(); set_eu_data(0);
    end
    bus.valid_i = 5'b11110;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00100) begin n_fail++; $display("FAIL lb_resume got=%b exp=%b", bus.ready_o, 5'b00100); end
    edge_update(); set_eu_data(2);
    bus.valid_i = 5'b00000;
    edge_update();
    bus.valid_i = 5'b01000;
    edge_update(); set_eu_data(3);
  endtask

  task automatic test_stall();
    cdb_data_t hold;
    cdb_data_t d;
    n_tests++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_pre_valid got=%b exp=1", bus.valid_o); end
    hold = bus.data_o;
    bus.valid_i = 5'b00110; bus.rob_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (bus.ready_o !== 5'b00000) begin n_fail++; $display("FAIL stall_ready[%0d] got=%b exp=%b", i, bus.ready_o, 5'b00000); end
      edge_update();
      n_tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== hold) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, bus.data_o, hold); end
    end
    bus.rob_ready_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00010) begin n_fail++; $display("FAIL stall_release got=%b exp=%b", bus.ready_o, 5'b00010); end
    d = bus.data_i[1];
    edge_update(); set_eu_data(1);
    n_tests++; if (bus.data_o !== d) begin n_fail++; $display("FAIL stall_new got=%h exp=%h", bus.data_o, d); end
    bus.valid_i = 5'b00100;
  endtask

  task automatic test_flush();
    bus.rob_ready_i = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00000) begin n_fail++; $display("FAIL flush_ready got=%b exp=%b", bus.ready_o, 5'b00000); end
    edge_update();
    n_tests++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus.valid_o); end
    flush = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ready_o !== 5'b00100) begin n_fail++; $display("FAIL flush_next got=%b exp=%b", bus.ready_o, 5'b00100); end
    edge_update(); set_eu_data(2);
    n_tests++; if (bus.valid_o !== 1'b1 || bus.data_o.rob_idx !== 3'd2) begin n_fail++; $display("FAIL flush_tag got=%b/%0d exp=1/2", bus.valid_o, bus.data_o.rob_idx); end
    bus.valid_i = 5'b00000;
    edge_update();
    n_tests++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", bus.valid_o); end
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic [N-1:0] exp;
    v = bus.valid_i;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1; set_eu_data(i);
        end
      end
      bus.valid_i     = v;
      bus.rob_ready_i = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 19) == 0);
      rst             = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      exp = ref_ready();
      n_tests++; if (bus.ready_o !== exp) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, bus.ready_o, exp); end
      edge_update();
      v = v & ~exp;
      n_tests++; if (bus.valid_o !== m_valid || (m_valid && bus.data_o !== m_data)) begin
        n_fail++; $display("FAIL rand_out[%0d] got=%b/%h exp=%b/%h", c, bus.valid_o, bus.data_o, m_valid, m_data);
      end
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.valid_i = 5'b00000; bus.rob_ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_eu_data(i);
    @(posedge clk); #1;
    test_reset();
`ifdef LEN5_CDB_LB_PRIO_EN
    test_lb_prio();
`else
    test_rotate();
    test_wrap_skip();
`endif
    test_stall();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
